// File: rtl/riscv_configs.sv
// rtl/riscv_configs.sv - shared constants for the writeback stage
// Purpose: default datapath width, result-select encodings, load funct3
// encodings and the writeback FSM state type.
package riscv_configs;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_load_ext.sv
// rtl/riscv_load_ext.sv - load data extraction and sign/zero extension
// Ports:
//   funct3_i  load size/sign (RISC-V funct3)
//   addr_i    byte offset within the XLEN-wide read word
//   data_i    aligned read word from data memory
//   data_o    extended load value; zero for a funct3 illegal at this XLEN
module riscv_load_ext
  import riscv_configs::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3_i,
  input  logic [OFF_W-1:0] addr_i,
  input  logic [XLEN-1:0]  data_i,
  output logic [XLEN-1:0]  data_o
);

  // Offset bits below the access size are ignored, so mask them before shifting.
  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  assign off_h  = addr_i & ~OFF_W'(1);
  assign off_w  = addr_i & ~OFF_W'(3);
  assign byte_v = 8'(data_i >> {addr_i, 3'b000});
  assign half_v = 16'(data_i >> {off_h, 3'b000});
  assign word_v = 32'(data_i >> {off_w, 3'b000});

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:  data_o = XLEN'($signed(byte_v));
      F3_LH:  data_o = XLEN'($signed(half_v));
      F3_LW:  data_o = XLEN'($signed(word_v));
      F3_LBU: data_o = XLEN'(byte_v);
      F3_LHU: data_o = XLEN'(half_v);
      F3_LD:  if (XLEN == 64) data_o = data_i;
      F3_LWU: if (XLEN == 64) data_o = XLEN'(word_v);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_mux.sv
// rtl/riscv_mux.sv - generic N-input word multiplexer
// Ports:
//   in_i   N_MUX_IN packed words of WIDTH bits, index 0 selected by sel_i == 0
//   sel_i  select
//   out_o  selected word
module riscv_mux #(
  parameter int WIDTH    = 32,
  parameter int N_MUX_IN = 4
) (
  input  logic [N_MUX_IN-1:0][WIDTH-1:0]  in_i,
  input  logic [$clog2(N_MUX_IN)-1:0]     sel_i,
  output logic [WIDTH-1:0]                out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/riscv_writeback_stage.sv
// rtl/riscv_writeback_stage.sv - registered MEM/WB stage with late-load wait
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_valid_m .. i_ext_imm_m      instruction fields from MEM
//   i_flush_w                     squash the instruction entering WB
//   i_read_data_w, i_read_valid_w data-memory response
//   o_result_w, o_rd_w, o_reg_write_w  register-file write port
//   o_stall_w                     WB waiting for load data, freezes IF..MEM
//   o_retire_w, o_retire_cnt      retire pulse and retired-instruction count
module riscv_writeback_stage
  import riscv_configs::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid_m,
  input  logic             i_reg_write_m,
  input  logic [4:0]       i_rd_m,
  input  logic [1:0]       i_result_src_m,
  input  logic [2:0]       i_funct3_m,
  input  logic [XLEN-1:0]  i_alu_result_m,
  input  logic [XLEN-1:0]  i_pc_plus_4m,
  input  logic [XLEN-1:0]  i_ext_imm_m,
  input  logic             i_flush_w,
  input  logic [XLEN-1:0]  i_read_data_w,
  input  logic             i_read_valid_w,
  output logic [XLEN-1:0]  o_result_w,
  output logic [4:0]       o_rd_w,
  output logic             o_reg_write_w,
  output logic             o_stall_w,
  output logic             o_retire_w,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic             valid_q, valid_d;
  logic             reg_write_q;
  logic [4:0]       rd_q;
  logic [1:0]       result_src_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  alu_q, pc4_q, imm_q;
  logic [XLEN-1:0]  word_q, word_d;
  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             is_load;
  logic             completing;
  logic             stall;
  logic             retire;
  logic             reg_write;
  logic [XLEN-1:0]  load_word;
  logic [XLEN-1:0]  load_val;
  logic [3:0][XLEN-1:0] mux_in;

  assign is_load    = valid_q & (result_src_q == RES_LOAD);
  // Everything except a load still missing its data finishes this cycle.
  assign completing = ~is_load | i_read_valid_w;
  assign load_word  = i_read_valid_w ? i_read_data_w : word_q;

  // Stall covers every WB cycle of a late load, including the one where the
  // data finally arrives; an on-time load never raises it.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      WB_RUN: begin
        if (is_load && !i_read_valid_w) begin
          state_d = WB_WAIT;
          stall   = 1'b1;
        end
      end
      WB_WAIT: begin
        stall = 1'b1;
        if (i_read_valid_w) state_d = WB_RUN;
      end
      default: state_d = WB_RUN;
    endcase
  end

  // The register only holds while a load is waiting; the edge that ends the
  // completing cycle takes the next MEM instruction even though stall was high.
  // While holding, i_flush_w has no effect, so a waiting load is never squashed.
  always_comb begin
    retire    = valid_q & completing;
    reg_write = retire & reg_write_q & (rd_q != 5'd0);
    valid_d   = completing ? (i_valid_m & ~i_flush_w) : valid_q;
    word_d    = (is_load && i_read_valid_w) ? i_read_data_w : word_q;
    cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= WB_RUN;
      valid_q <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_q        <= '0;
      pc4_q        <= '0;
      imm_q        <= '0;
    end else if (completing) begin
      reg_write_q  <= i_reg_write_m;
      rd_q         <= i_rd_m;
      result_src_q <= i_result_src_m;
      funct3_q     <= i_funct3_m;
      alu_q        <= i_alu_result_m;
      pc4_q        <= i_pc_plus_4m;
      imm_q        <= i_ext_imm_m;
    end
  end

  riscv_load_ext #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_load_ext (
    .funct3_i(funct3_q),
    .addr_i  (alu_q[OFF_W-1:0]),
    .data_i  (load_word),
    .data_o  (load_val)
  );

  always_comb begin
    mux_in           = '0;
    mux_in[RES_ALU]  = alu_q;
    mux_in[RES_LOAD] = load_val;
    mux_in[RES_PC4]  = pc4_q;
    mux_in[RES_IMM]  = imm_q;
  end

  riscv_mux #(
    .WIDTH   (XLEN),
    .N_MUX_IN(4)
  ) u_result_mux (
    .in_i (mux_in),
    .sel_i(result_src_q),
    .out_o(o_result_w)
  );

  assign o_rd_w        = rd_q;
  assign o_reg_write_w = reg_write;
  assign o_stall_w     = stall;
  assign o_retire_w    = retire;
  assign o_retire_cnt  = cnt_q;

endmodule
